lcd_refresh_sequencer: RTL
==========================

// Module: lcd_refresh_sequencer
// PURPOSE
//   Sequences HD44780-style character writes from a LINES x CHARS display buffer onto the LCD bus.
//   Takes over the bus once the initializer asserts done; the top-level mux selects it while initilized=1.
//   Per frame, for each line: one Set-DDRAM-Address command, then CHARS data writes.
//   After each frame it idles REFRESH_CYC cycles, then starts the next frame.
// PARAMETERS
//   LINES        4                               lines on the LCD
//   CHARS        20                              characters per line
//   LINE_STARTS  {7'h00,7'h40,7'h14,7'h54}       [0:LINES-1][6:0] DDRAM start address per line
//   E_PULSE_CYC  25                              E high time in clk cycles (500 ns @ 50 MHz), >=1
//   CMD_WAIT_CYC 2500                            post-E settle/exec wait in cycles (50 us), >=1
//   REFRESH_CYC  2500000                         idle cycles between frames (50 ms), >=1
// PORTS
//   clk            in   1          50 MHz clock, all logic rising-edge
//   reset          in   1          synchronous, active-high
//   initilized     in   1          LCD initializer done; sequencer runs only while 1
//   display_chars  in   8 x L x C  [7:0] [0:LINES-1][0:CHARS-1] ASCII buffer, [l][0] leftmost
//   RS             out  1          0=command, 1=data
//   RW             out  1          tied 0 (write only)
//   E              out  1          enable strobe
//   DATA           out  8          LCD data bus value
//   busy           out  1          1 in any state except IDLE/HOLD
//   frame_done     out  1          one-cycle pulse after the last char of the last line completes its wait
// BEHAVIOUR
//   Reset (and initilized=0): state=IDLE, RS=0, RW=0, E=0, DATA=8'h00, busy=0, frame_done=0, line/char counters=0.
//   States: IDLE -> ADDR_SETUP -> E_HIGH -> E_WAIT -> {CHAR_SETUP|ADDR_SETUP|DONE} ; CHAR_SETUP -> E_HIGH -> E_WAIT ; DONE -> HOLD -> ADDR_SETUP.
//   IDLE: leave on first cycle initilized=1 (registered) -> ADDR_SETUP, line=0.
//   ADDR_SETUP (1 cycle): RS=0, DATA={1'b1,LINE_STARTS[line]}, E=0.
//   CHAR_SETUP (1 cycle): RS=1, DATA=display_chars[line][char], E=0.
//   E_HIGH: E=1 for exactly E_PULSE_CYC cycles; RS/DATA held stable.
//   E_WAIT: E=0 for exactly CMD_WAIT_CYC cycles; RS/DATA held stable.
//   End of E_WAIT: after an addr cmd -> CHAR_SETUP char=0; after char<CHARS-1 -> CHAR_SETUP char+1;
//     after char=CHARS-1 and line<LINES-1 -> ADDR_SETUP line+1; after last char of last line -> DONE.
//   Byte period = 1+E_PULSE_CYC+CMD_WAIT_CYC cycles; frame = LINES*(CHARS+1) byte periods.
//   DONE (1 cycle): frame_done=1, counters cleared -> HOLD.
//   HOLD: REFRESH_CYC cycles, E=0, busy=0, then ADDR_SETUP line=0.
//   Counters: line ceil(log2 LINES), char ceil(log2 CHARS), timer ceil(log2 max(E_PULSE_CYC,CMD_WAIT_CYC,REFRESH_CYC)+1); no wrap past limits.
//   initilized falling in any state: next cycle IDLE with reset output values (abort mid-byte; E drops immediately).
//   reset has priority over initilized; reset mid-E_HIGH forces E=0 next cycle.
//   display_chars sampled only in CHAR_SETUP (live buffer, byte-by-byte), unless snapshot enabled.
// CONFIGURATION
//   LCD_FRAME_SNAPSHOT_EN defined: whole display_chars captured into an internal LINES x CHARS register
//     in the cycle the FSM enters ADDR_SETUP for line 0; CHAR_SETUP reads the copy -> tear-free frames.
//   Undefined: no copy registers; CHAR_SETUP reads display_chars directly (mid-frame edits appear immediately).
// TESTING  (bench params: LINES=2, CHARS=3, LINE_STARTS={7'h00,7'h40}, E_PULSE_CYC=2, CMD_WAIT_CYC=3, REFRESH_CYC=4; byte period 6)
//   1 reset=1 for 3 cycles, initilized=0 -> RS=0, RW=0, E=0, DATA=00, busy=0, frame_done=0 throughout.
//   2 buffer "ABC"/"xyz", initilized=1 -> bytes RS/DATA: 0/80,1/41,1/42,1/43,0/C0,1/78,1/79,1/7A; E high 2 cycles each, 6-cycle spacing.
//   3 same run -> frame_done single pulse 48 cycles after first ADDR_SETUP; next 0/80 setup exactly 1+4 cycles after the pulse.
//   4 drop initilized during E_HIGH of 2nd char -> next cycle E=0, DATA=00, busy=0; reassert -> restarts at 0/80.
//   5 reset=1 during E_WAIT of line-1 addr cmd -> all outputs at reset values next cycle; after release frame restarts at line 0.
//   6 change [0][2] 'C'->'Q' after byte 0/80 issued: without LCD_FRAME_SNAPSHOT_EN third data byte 51; with it 43, 51 in next frame.

Source files
------------

// File: rtl/lcd_bus_if.sv
// HD44780-style LCD write bus: register select, read/write, enable strobe and data byte.
interface lcd_bus_if;
  logic       RS;
  logic       RW;
  logic       E;
  logic [7:0] DATA;

  modport master (output RS, RW, E, DATA);
  modport slave  (input  RS, RW, E, DATA);
endinterface

// File: rtl/lcd_refresh_sequencer.sv
// Streams a LINES x CHARS character buffer to an HD44780 LCD, one frame per refresh period.
// Optional LCD_FRAME_SNAPSHOT_EN: latch the whole buffer at frame start for tear-free frames.
module lcd_refresh_sequencer #(
  parameter int LINES        = 4,
  parameter int CHARS        = 20,
  parameter logic [0:LINES-1][6:0] LINE_STARTS = {7'h00, 7'h40, 7'h14, 7'h54},
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int REFRESH_CYC  = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic initilized,
  input  logic [0:LINES-1][0:CHARS-1][7:0] display_chars,
  lcd_bus_if.master bus,
  output logic busy,
  output logic frame_done
);
  localparam int LW   = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CW   = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int MAX1 = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAXC = (MAX1 > REFRESH_CYC) ? MAX1 : REFRESH_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_SETUP, CHAR_SETUP, E_HIGH, E_WAIT, DONE, HOLD
  } state_t;

  state_t          state, state_n;
  logic [LW-1:0]   line, line_n;
  logic [CW-1:0]   chr, chr_n;
  logic [TW-1:0]   timer, timer_n;
  logic            rs_q, rs_c;
  logic [7:0]      data_q, data_c;
  logic [0:LINES-1][0:CHARS-1][7:0] src;

`ifdef LCD_FRAME_SNAPSHOT_EN
  logic [0:LINES-1][0:CHARS-1][7:0] snap;

  // Capture on the edge that enters line 0's address setup, i.e. the start of every frame.
  always_ff @(posedge clk) begin
    if ((state == IDLE || state == HOLD) && state_n == ADDR_SETUP)
      snap <= display_chars;
  end
  assign src = snap;
`else
  assign src = display_chars;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      line   <= '0;
      chr    <= '0;
      timer  <= '0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      state <= state_n;
      line  <= line_n;
      chr   <= chr_n;
      timer <= timer_n;
      if (state == ADDR_SETUP || state == CHAR_SETUP) begin
        rs_q   <= rs_c;
        data_q <= data_c;
      end
    end
  end

  always_comb begin
    state_n = state;
    line_n  = line;
    chr_n   = chr;
    timer_n = timer;
    case (state)
      IDLE: begin
        line_n  = '0;
        chr_n   = '0;
        timer_n = '0;
        state_n = ADDR_SETUP;
      end
      ADDR_SETUP, CHAR_SETUP: begin
        timer_n = '0;
        state_n = E_HIGH;
      end
      E_HIGH: begin
        if (timer == TW'(E_PULSE_CYC - 1)) begin
          timer_n = '0;
          state_n = E_WAIT;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      E_WAIT: begin
        if (timer == TW'(CMD_WAIT_CYC - 1)) begin
          timer_n = '0;
          // rs_q tells us whether the byte just finished was the line's address command.
          if (!rs_q) begin
            chr_n   = '0;
            state_n = CHAR_SETUP;
          end else if (chr != CW'(CHARS - 1)) begin
            chr_n   = chr + CW'(1);
            state_n = CHAR_SETUP;
          end else if (line != LW'(LINES - 1)) begin
            line_n  = line + LW'(1);
            state_n = ADDR_SETUP;
          end else begin
            state_n = DONE;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      DONE: begin
        line_n  = '0;
        chr_n   = '0;
        timer_n = '0;
        state_n = HOLD;
      end
      HOLD: begin
        if (timer == TW'(REFRESH_CYC - 1)) begin
          timer_n = '0;
          state_n = ADDR_SETUP;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (!initilized) begin
      state_n = IDLE;
      line_n  = '0;
      chr_n   = '0;
      timer_n = '0;
    end
  end

  always_comb begin
    rs_c   = 1'b0;
    data_c = 8'h00;
    case (state)
      ADDR_SETUP: data_c = {1'b1, LINE_STARTS[line]};
      CHAR_SETUP: begin
        rs_c   = 1'b1;
        data_c = src[line][chr];
      end
      E_HIGH, E_WAIT: begin
        rs_c   = rs_q;
        data_c = data_q;
      end
      default: ;
    endcase
  end

  assign bus.RS     = rs_c;
  assign bus.RW     = 1'b0;
  assign bus.E      = (state == E_HIGH);
  assign bus.DATA   = data_c;
  assign busy       = (state != IDLE) && (state != HOLD);
  assign frame_done = (state == DONE);
endmodule
